// File: rtl/per2axi_req_arbiter.sv
// per2axi_req_arbiter: round-robin arbiter sharing the per2axi request channel among cores,
// holding a stalled request stable and throttling cores by outstanding-transaction count.
module per2axi_req_arbiter #(
  parameter int NB_CORES       = 4,
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int MAX_OUTST      = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NB_CORES-1:0]                       core_req_i,
  input  logic [NB_CORES*PER_ADDR_WIDTH-1:0]        core_add_i,
  input  logic [NB_CORES-1:0]                       core_we_i,
  input  logic [NB_CORES*6-1:0]                     core_atop_i,
  input  logic [NB_CORES*32-1:0]                    core_wdata_i,
  input  logic [NB_CORES*4-1:0]                     core_be_i,
  output logic [NB_CORES-1:0]                       core_gnt_o,
  output logic                                      per_req_o,
  output logic [PER_ADDR_WIDTH-1:0]                 per_add_o,
  output logic                                      per_we_o,
  output logic [5:0]                                per_atop_o,
  output logic [31:0]                               per_wdata_o,
  output logic [3:0]                                per_be_o,
  output logic [PER_ID_WIDTH-1:0]                   per_id_o,
  input  logic                                      per_gnt_i,
  input  logic                                      resp_valid_i,
  input  logic [PER_ID_WIDTH-1:0]                   resp_id_i,
  output logic [NB_CORES*$clog2(MAX_OUTST+1)-1:0]   outst_o,
  output logic                                      err_o
);
  localparam int CW = $clog2(MAX_OUTST+1);
  localparam int IW = NB_CORES > 1 ? $clog2(NB_CORES) : 1;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, sel_q, sel_d, win, src;
  logic lock_q, lock_d, err_q, err_d, found, gnt;
  logic [NB_CORES-1:0][CW-1:0] outst_q, outst_d;
  logic [NB_CORES-1:0] elig, zero, inc, dec;
  logic unused_ok;
  int j;
  always_comb begin
    elig = '0;
    zero = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      elig[k] = core_req_i[k] && (outst_q[k] < CW'(MAX_OUTST));
      zero[k] = outst_q[k] == '0;
    end
  end
  always_comb begin
    win = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < NB_CORES; i++) begin
      j = (int'(rr_ptr_q) + i) % NB_CORES;
      if (!found && elig[j]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
  end
  // A stalled request stays on the locked source even if it stops being eligible
  assign src         = lock_q ? sel_q : win;
  assign per_req_o   = !rst_i && (lock_q || found);
  assign gnt         = per_req_o && per_gnt_i;
  assign core_gnt_o  = gnt ? (NB_CORES'(1) << src) : '0;
  assign per_id_o    = per_req_o ? (PER_ID_WIDTH'(1) << src) : '0;
  assign per_add_o   = per_req_o ? core_add_i[src*PER_ADDR_WIDTH +: PER_ADDR_WIDTH] : '0;
  assign per_we_o    = per_req_o && core_we_i[src];
  assign per_atop_o  = per_req_o ? core_atop_i[src*6 +: 6] : '0;
  assign per_wdata_o = per_req_o ? core_wdata_i[src*32 +: 32] : '0;
  assign per_be_o    = per_req_o ? core_be_i[src*4 +: 4] : '0;
  assign outst_o     = outst_q;
  assign err_o       = err_q;
  assign inc         = core_gnt_o;
  assign dec         = resp_valid_i ? resp_id_i[NB_CORES-1:0] : '0;
  assign unused_ok   = ^resp_id_i;
  assign lock_d   = (per_req_o && !per_gnt_i) ? 1'b1 : gnt ? 1'b0 : lock_q;
  assign sel_d    = (per_req_o && !per_gnt_i) ? src : sel_q;
  assign rr_ptr_d = gnt ? ((src == IW'(NB_CORES-1)) ? '0 : src + 1'b1) : rr_ptr_q;
  assign err_d    = |(dec & ~inc & zero);
  always_comb begin
    outst_d = outst_q;
    for (int k = 0; k < NB_CORES; k++)
      outst_d[k] = (inc[k] && !dec[k]) ? outst_q[k] + 1'b1 :
                   (dec[k] && !inc[k] && !zero[k]) ? outst_q[k] - 1'b1 : outst_q[k];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      outst_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      outst_q  <= outst_d;
    end
  end
endmodule

// File: tb/tb_per2axi_req_arbiter.sv
// tb_per2axi_req_arbiter: directed scenarios plus random traffic checked every cycle
// against a behavioural model of the arbiter's rules.
module tb_per2axi_req_arbiter;
  localparam int NB = 4, AW = 32, IDW = 5, MO = 4, CW = 3;
  logic clk = 1'b0, rst;
  logic [NB-1:0] req, we, core_gnt;
  logic [NB*AW-1:0] add;
  logic [NB*6-1:0] atop;
  logic [NB*32-1:0] wdata;
  logic [NB*4-1:0] be;
  logic per_req, per_we, gnt_in, resp_valid, err;
  logic [AW-1:0] per_add;
  logic [5:0] per_atop;
  logic [31:0] per_wdata;
  logic [3:0] per_be;
  logic [IDW-1:0] per_id, resp_id;
  logic [NB*CW-1:0] outst;
  int n_tot = 0, n_bad = 0;
  int cnt[NB];
  int ptr, sl, m_src;
  bit lk, errq, m_req;
  logic obs_req, obs_err;
  logic [IDW-1:0] obs_id;
  logic [NB-1:0] obs_gnt;
  logic [NB*CW-1:0] obs_outst;

  always #5 clk = ~clk;

  per2axi_req_arbiter #(.NB_CORES(NB), .PER_ADDR_WIDTH(AW), .PER_ID_WIDTH(IDW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_i(rst), .core_req_i(req), .core_add_i(add), .core_we_i(we),
    .core_atop_i(atop), .core_wdata_i(wdata), .core_be_i(be), .core_gnt_o(core_gnt),
    .per_req_o(per_req), .per_add_o(per_add), .per_we_o(per_we), .per_atop_o(per_atop),
    .per_wdata_o(per_wdata), .per_be_o(per_be), .per_id_o(per_id), .per_gnt_i(gnt_in),
    .resp_valid_i(resp_valid), .resp_id_i(resp_id), .outst_o(outst), .err_o(err));

  always @(posedge clk) if (!rst && resp_valid) assert ($onehot0(resp_id)) else $error("illegal multi-bit resp id");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    foreach (cnt[k]) cnt[k] = 0;
    ptr = 0; sl = 0; lk = 0; errq = 0;
  endfunction

  // Winner: locked source, else first eligible core scanning from the pointer with wrap
  function automatic void m_eval();
    m_req = 0; m_src = 0;
    if (rst) return;
    if (lk) begin m_req = 1; m_src = sl; return; end
    for (int i = 0; i < NB; i++) begin
      int c = (ptr + i) % NB;
      if (req[c] && cnt[c] < MO) begin m_req = 1; m_src = c; return; end
    end
  endfunction

  task automatic cycle();
    logic [NB*CW-1:0] eo;
    bit g, en;
    int nx;
    if (rst) m_reset();
    #1;
    m_eval();
    eo = '0;
    for (int k = 0; k < NB; k++) eo[k*CW +: CW] = CW'(cnt[k]);
    check("req", per_req, m_req);
    check("id", per_id, m_req ? 64'(1) << m_src : 64'(0));
    check("gnt", core_gnt, (m_req && gnt_in) ? 64'(1) << m_src : 64'(0));
    check("add", per_add, m_req ? 64'(add[m_src*AW +: AW]) : 64'(0));
    check("wdata", per_wdata, m_req ? 64'(wdata[m_src*32 +: 32]) : 64'(0));
    check("atop", per_atop, m_req ? 64'(atop[m_src*6 +: 6]) : 64'(0));
    check("be", per_be, m_req ? 64'(be[m_src*4 +: 4]) : 64'(0));
    check("we", per_we, m_req && we[m_src]);
    check("outst", outst, eo);
    check("err", err, errq);
    obs_req = per_req; obs_id = per_id; obs_gnt = core_gnt; obs_err = err; obs_outst = outst;
    @(posedge clk);
    if (rst) m_reset();
    else begin
      g = m_req && gnt_in;
      if (m_req && !gnt_in) begin lk = 1; sl = m_src; end
      if (g) begin lk = 0; ptr = (m_src + 1) % NB; end
      en = 0;
      for (int k = 0; k < NB; k++) begin
        nx = cnt[k] + ((g && m_src == k) ? 1 : 0) - ((resp_valid && resp_id[k]) ? 1 : 0);
        if (nx < 0) begin nx = 0; en = 1; end
        cnt[k] = nx;
      end
      errq = en;
    end
    @(negedge clk);
  endtask

  task automatic rand_payload();
    add = {$urandom, $urandom, $urandom, $urandom};
    wdata = {$urandom, $urandom, $urandom, $urandom};
    atop = 24'($urandom);
    be = 16'($urandom);
    we = 4'($urandom);
  endtask

  task automatic do_reset();
    rst = 1; req = '0; gnt_in = 0; resp_valid = 0; resp_id = '0;
    cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; req = '0; gnt_in = 0; resp_valid = 0; resp_id = '0;
    rand_payload();
    @(negedge clk);
    do_reset();
    // round-robin with continuous grant
    req = 4'hf; gnt_in = 1;
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      cycle();
      check("rr_id", obs_id, 64'(1) << (i % 4));
    end
    // reset mid-stream, outstanding count of core 0 is 2
    rst = 1;
    cycle();
    check("rst_req", obs_req, 0);
    check("rst_outst", obs_outst, 0);
    rst = 0;
    cycle();
    check("rst_first", obs_gnt, 1);
    // lock while stalled
    do_reset();
    req = 4'b0100; gnt_in = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req[0] = 1;
      rand_payload();
      cycle();
      check("lock_id", obs_id, 4);
    end
    gnt_in = 1;
    cycle();
    check("lock_gnt", obs_gnt, 4);
    req = 4'b0001;
    cycle();
    check("after_lock", obs_gnt, 1);
    // throttle at MAX_OUTST
    do_reset();
    req = 4'b0010; gnt_in = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("thr_gnt", obs_gnt, 2);
    end
    resp_valid = 1; resp_id = 5'b00010;
    cycle();
    check("thr_block", obs_req, 0);
    resp_valid = 0;
    cycle();
    check("thr_resume", obs_gnt, 2);
    // grant and retire in the same cycle
    do_reset();
    req = 4'b0001; gnt_in = 1;
    cycle(); cycle();
    resp_valid = 1; resp_id = 5'b00001;
    cycle();
    check("sim_gnt", obs_gnt, 1);
    resp_valid = 0; req = '0;
    cycle();
    check("sim_outst", obs_outst[CW-1:0], 2);
    // retire with nothing outstanding
    do_reset();
    resp_valid = 1; resp_id = 5'b01000;
    cycle();
    resp_valid = 0;
    cycle();
    check("err_pulse", obs_err, 1);
    check("err_outst", obs_outst[3*CW +: CW], 0);
    cycle();
    check("err_clear", obs_err, 0);
    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = 4'($urandom);
      gnt_in = ($urandom_range(0, 3) != 0);
      resp_valid = ($urandom_range(0, 2) == 0);
      resp_id = IDW'(1) << $urandom_range(0, IDW-1);
      rand_payload();
      cycle();
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
